mem_access: RTL and testbench
=============================

MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  synchronous reset, active high (`RstEnable = 1'b1).
REQ-004 rdy  in  1  1 = advance; 0 = freeze all state.
REQ-005 opcode_i  in  7  opcode from ex_mem; LOAD_OP = 7'b0000011, STORE_OP = 7'b0100011.
REQ-006 funct3_i  in  3  access width and sign: LB/LH/LW/LBU/LHU = 0/1/2/4/5; SB/SH/SW = 0/1/2.
REQ-007 wd_i, wreg_i, wdata_i  in  5/1/32  ex result: destination, write enable, ALU data.
REQ-008 mem_addr_i, store_data_i  in  32/32  effective byte address and store operand.
REQ-009 mem_din_i  in  8  RAM read byte, valid one cycle after its address is presented.
REQ-010 mem_a_o, mem_dout_o, mem_wr_o  out  32/8/1  registered RAM byte address, write byte, write strobe.
REQ-011 wd_o, wreg_o, wdata_o  out  5/1/32  result toward mem_wb.
REQ-012 stall_req_o  out  1  1 = hold ex_mem and earlier stages.

Function
REQ-013 Non-memory opcode in IDLE SHALL pass wd_i/wreg_i/wdata_i combinationally to the outputs with stall_req_o = 0, mem_wr_o = 0 and mem_a_o = 0.
REQ-014 Byte count N SHALL be 1 for LB/LBU/SB, 2 for LH/LHU/SH and 4 for LW/SW; byte order SHALL be little-endian.
REQ-015 Bytes SHALL be accessed at addr+0 to addr+N-1; a misaligned address SHALL be legal and SHALL need no special handling.
REQ-016 FSM states SHALL be IDLE, ACCESS (byte index k = 0..N-1) and WAIT; WAIT SHALL be used by loads only.
REQ-017 T0 SHALL be the IDLE cycle in which a LOAD/STORE opcode is present; in T0 stall_req_o SHALL be 1 and the next edge SHALL enter ACCESS with k = 0.
REQ-018 In ACCESS cycle T(k+1) the block SHALL drive mem_a_o = addr+k; a store SHALL also drive mem_wr_o = 1 and mem_dout_o = store_data_i[8k+7:8k].
REQ-019 A load SHALL capture mem_din_i for byte k in cycle T(k+2); the last byte SHALL be captured in WAIT at T(N+1), used combinationally in that cycle.
REQ-020 Store: stall_req_o SHALL be 1 during T0..T(N-1) and 0 at T(N); at T(N) wreg_o SHALL be 0; the next edge SHALL return to IDLE.
REQ-021 Load: stall_req_o SHALL be 1 during T0..T(N); at T(N+1) it SHALL be 0 with wreg_o = wreg_i, wd_o = wd_i and wdata_o = the assembled value; the next edge SHALL return to IDLE.
REQ-022 LB/LH SHALL sign-extend from bit 7/15; LBU/LHU SHALL zero-extend; LW SHALL use all 32 bits.
REQ-023 While stalled (stall_req_o = 1 and before the final cycle), wreg_o SHALL be 0.
REQ-024 rdy = 0 SHALL freeze state, k and captured bytes; mem_wr_o SHALL be 0, and the access SHALL resume unchanged when rdy = 1.
REQ-025 An instruction arriving at the edge that returns the FSM to IDLE SHALL be handled as a new T0; back-to-back accesses SHALL NOT insert idle cycles.
REQ-026 An unlisted funct3 with LOAD/STORE opcode SHALL be treated as a 4-byte access.

Reset
REQ-027 rst = 1 at any edge SHALL force IDLE, k = 0, captured bytes = 0, and mem_a_o = 0, mem_dout_o = 0, mem_wr_o = 0; this SHALL abort an access in progress with no further RAM write.
REQ-028 While rst = 1, wd_o = 0, wreg_o = 0, wdata_o = 0 and stall_req_o = 0.

Structure
REQ-029 LOAD_OP, STORE_OP, the funct3 codes, FSM state encodings, `RstEnable and `ZeroWord SHALL reside in defines.v.
REQ-030 Byte assembly and sign/zero extension SHALL be one combinational sub-module, mem_load_ext (inputs: 4 bytes, funct3; output: 32-bit value).

Verification
REQ-031 Pass-through: ADDI result wd_i = 5, wdata_i = 0x0000002A -> same cycle wd_o = 5, wdata_o = 0x2A, stall_req_o = 0, mem_wr_o = 0.
REQ-032 SW at 0x1001 with data 0xDEADBEEF -> writes 0xEF, 0xBE, 0xAD, 0xDE to 0x1001..0x1004 in T1..T4; stall_req_o = 0 at T4.
REQ-033 LB and LBU of byte 0x80 -> wdata_o = 0xFFFFFF80 and 0x00000080 respectively, each at T2.
REQ-034 LW of bytes 0x78, 0x56, 0x34, 0x12 -> wdata_o = 0x12345678 at T5; stall_req_o high for exactly T0..T4.
REQ-035 rdy = 0 for 3 cycles after T2 of an SH -> no mem_wr_o pulses while frozen; the remaining byte is written once after resume.
REQ-036 rst pulsed at T2 of an SW -> mem_wr_o = 0 from the next cycle; only bytes 0-1 written; the next instruction starts at IDLE.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared opcodes, access-width codes and FSM state type for the byte-serial memory stage.
package mem_access_pkg;

    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    localparam logic [6:0] LOAD_OP  = 7'b0000011;
    localparam logic [6:0] STORE_OP = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT
    } state_t;

    // Index of the last byte of an access; unlisted codes fall back to a full word.
    function automatic logic [1:0] last_index(input logic [2:0] funct3, input logic is_store);
        logic [1:0] idx;
        case (funct3)
            F3_B:    idx = 2'd0;
            F3_H:    idx = 2'd1;
            F3_BU:   idx = is_store ? 2'd3 : 2'd0;
            F3_HU:   idx = is_store ? 2'd3 : 2'd1;
            default: idx = 2'd3;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/mem_access_load_ext.sv
// Assembles little-endian load bytes and applies sign or zero extension.
module mem_load_ext
    import mem_access_pkg::*;
(
    input  logic [7:0]  byte0,
    input  logic [7:0]  byte1,
    input  logic [7:0]  byte2,
    input  logic [7:0]  byte3,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    always_comb begin
        value = {byte3, byte2, byte1, byte0};
        case (funct3)
            F3_B:    value = {{24{byte0[7]}}, byte0};
            F3_H:    value = {{16{byte1[7]}}, byte1, byte0};
            F3_BU:   value = {24'h000000, byte0};
            F3_HU:   value = {16'h0000, byte1, byte0};
            default: value = {byte3, byte2, byte1, byte0};
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage that serialises loads/stores over a byte-wide RAM port,
// stalling the earlier pipeline stages until the access completes.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] store_data_i,
    input  logic [7:0]  mem_din_i,
    output logic [31:0] mem_a_o,
    output logic [7:0]  mem_dout_o,
    output logic        mem_wr_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stall_req_o
);

    state_t      state;
    logic [1:0]  k;
    logic [7:0]  cap [4];
    logic        mem_wr_q;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic [1:0]  last_k;
    logic [1:0]  next_k;
    logic [7:0]  ld_byte [4];
    logic [31:0] load_value;

    assign is_load  = (opcode_i == LOAD_OP);
    assign is_store = (opcode_i == STORE_OP);
    assign is_mem   = is_load | is_store;
    assign last_k   = last_index(funct3_i, is_store);
    assign next_k   = k + 2'd1;

    // The final byte is never registered: it is taken straight from the RAM in WAIT.
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            ld_byte[i] = (2'(i) == last_k) ? mem_din_i : cap[i];
        end
    end

    mem_load_ext u_load_ext (
        .byte0  (ld_byte[0]),
        .byte1  (ld_byte[1]),
        .byte2  (ld_byte[2]),
        .byte3  (ld_byte[3]),
        .funct3 (funct3_i),
        .value  (load_value)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state      <= ST_IDLE;
            k          <= '0;
            for (int unsigned i = 0; i < 4; i++) cap[i] <= '0;
            mem_a_o    <= '0;
            mem_dout_o <= '0;
            mem_wr_q   <= 1'b0;
        end else if (rdy) begin
            unique case (state)
                ST_IDLE: begin
                    k <= '0;
                    if (is_mem) begin
                        state      <= ST_ACCESS;
                        mem_a_o    <= mem_addr_i;
                        mem_dout_o <= is_store ? store_data_i[7:0] : 8'h00;
                        mem_wr_q   <= is_store;
                    end
                end
                ST_ACCESS: begin
                    // RAM data lags the address by one cycle, so byte k-1 lands now.
                    if (is_load && k != 2'd0) cap[k - 2'd1] <= mem_din_i;
                    if (k == last_k) begin
                        k          <= '0;
                        mem_dout_o <= '0;
                        mem_wr_q   <= 1'b0;
                        if (is_store) begin
                            state   <= ST_IDLE;
                            mem_a_o <= '0;
                        end else begin
                            state   <= ST_WAIT;
                        end
                    end else begin
                        k          <= next_k;
                        mem_a_o    <= mem_addr_i + {30'd0, next_k};
                        mem_dout_o <= is_store ? store_data_i[{next_k, 3'b000} +: 8] : 8'h00;
                        mem_wr_q   <= is_store;
                    end
                end
                ST_WAIT: begin
                    state   <= ST_IDLE;
                    mem_a_o <= '0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_wr_o = mem_wr_q & rdy;

    always_comb begin
        wd_o        = wd_i;
        wreg_o      = wreg_i;
        wdata_o     = wdata_i;
        stall_req_o = 1'b0;
        if (rst == RST_ENABLE) begin
            wd_o    = '0;
            wreg_o  = 1'b0;
            wdata_o = ZERO_WORD;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (is_mem) begin
                        stall_req_o = 1'b1;
                        wreg_o      = 1'b0;
                    end
                end
                ST_ACCESS: begin
                    wreg_o      = 1'b0;
                    stall_req_o = !(is_store && k == last_k);
                end
                ST_WAIT: begin
                    wdata_o = load_value;
                end
                default: begin
                    wreg_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: byte-wide RAM model, expected writes and results in queues.
module tb_mem_access;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [31:0] mem_addr_i;
    logic [31:0] store_data_i;
    logic [7:0]  mem_din_i;
    logic [31:0] mem_a_o;
    logic [7:0]  mem_dout_o;
    logic        mem_wr_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stall_req_o;

    mem_access dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .opcode_i     (opcode_i),
        .funct3_i     (funct3_i),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .mem_addr_i   (mem_addr_i),
        .store_data_i (store_data_i),
        .mem_din_i    (mem_din_i),
        .mem_a_o      (mem_a_o),
        .mem_dout_o   (mem_dout_o),
        .mem_wr_o     (mem_wr_o),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .stall_req_o  (stall_req_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous-read RAM; its read register holds while rdy is low.
    bit [7:0] ram [int unsigned];
    always @(posedge clk) begin
        if (rdy) mem_din_i <= ram.exists(mem_a_o) ? ram[mem_a_o] : 8'h00;
        if (mem_wr_o) ram[mem_a_o] = mem_dout_o;
    end

    logic [39:0] wr_exp [$];
    logic [36:0] res_exp [$];
    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mem_wr_o === 1'b1) begin
            if (wr_exp.size() == 0) check("wr_unexpected", 64'(mem_wr_o), 64'd0);
            else check("wr", 64'({mem_a_o, mem_dout_o}), 64'(wr_exp.pop_front()));
        end
        if (rst === 1'b0 && rdy && stall_req_o === 1'b0 && wreg_o === 1'b1) begin
            if (res_exp.size() == 0) check("res_unexpected", 64'(wreg_o), 64'd0);
            else check("res", 64'({wd_o, wdata_o}), 64'(res_exp.pop_front()));
        end
    end

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [4:0] wd, input logic wr,
                          input logic [31:0] wdat);
        opcode_i = op; funct3_i = f3; mem_addr_i = addr; store_data_i = sd;
        wd_i = wd; wreg_i = wr; wdata_i = wdat;
    endtask

    task automatic exp_store(input logic [31:0] addr, input logic [31:0] sd, input int n);
        for (int i = 0; i < n; i++) wr_exp.push_back({addr + 32'(i), sd[8*i +: 8]});
    endtask

    // Drives one instruction from its T0 and holds it until the stage releases the pipeline.
    task automatic issue(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sd, input logic [4:0] wd,
                         input logic wr, input logic [31:0] wdat, input int exp_cycles);
        int  cycles;
        bit  done;
        cycles = 0;
        done   = 1'b0;
        set_in(op, f3, addr, sd, wd, wr, wdat);
        while (!done && cycles < 50) begin
            @(negedge clk);
            cycles++;
            if (stall_req_o === 1'b1) check({tag, "_wreg_stall"}, 64'(wreg_o), 64'd0);
            done = (stall_req_o === 1'b0) && rdy;
            @(posedge clk);
            #1;
        end
        check({tag, "_cycles"}, 64'(cycles), 64'(exp_cycles));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ram[32'h1100] = 8'h80;
        ram[32'h1200] = 8'h78;
        ram[32'h1201] = 8'h56;
        ram[32'h1202] = 8'h34;
        ram[32'h1203] = 8'h12;

        rst = 1'b1;
        rdy = 1'b1;
        set_in(OP_LOAD, 3'd2, 32'h1200, 32'h0, 5'd3, 1'b1, 32'hFFFF);
        #1;
        check("rst_wd", 64'(wd_o), 64'd0);
        check("rst_wreg", 64'(wreg_o), 64'd0);
        check("rst_wdata", 64'(wdata_o), 64'd0);
        check("rst_stall", 64'(stall_req_o), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_a", 64'(mem_a_o), 64'd0);
        check("rst_mem_wr", 64'(mem_wr_o), 64'd0);
        check("rst_mem_dout", 64'(mem_dout_o), 64'd0);
        rst = 1'b0;
        set_in(OP_ADDI, 3'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_002A);
        #1;
        check("pass_wd", 64'(wd_o), 64'd5);
        check("pass_wdata", 64'(wdata_o), 64'h2A);
        check("pass_stall", 64'(stall_req_o), 64'd0);
        check("pass_mem_wr", 64'(mem_wr_o), 64'd0);
        check("pass_mem_a", 64'(mem_a_o), 64'd0);
        res_exp.push_back({5'd5, 32'h0000_002A});
        issue("addi", OP_ADDI, 3'd0, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_002A, 1);

        exp_store(32'h1001, 32'hDEAD_BEEF, 4);
        issue("sw", OP_STORE, 3'd2, 32'h1001, 32'hDEAD_BEEF, 5'd9, 1'b1, 32'h1001, 5);

        res_exp.push_back({5'd1, 32'hFFFF_FF80});
        issue("lb", OP_LOAD, 3'd0, 32'h1100, 32'h0, 5'd1, 1'b1, 32'h1100, 3);
        res_exp.push_back({5'd2, 32'h0000_0080});
        issue("lbu", OP_LOAD, 3'd4, 32'h1100, 32'h0, 5'd2, 1'b1, 32'h1100, 3);
        res_exp.push_back({5'd3, 32'h1234_5678});
        issue("lw", OP_LOAD, 3'd2, 32'h1200, 32'h0, 5'd3, 1'b1, 32'h1200, 6);
        res_exp.push_back({5'd4, 32'hFFFF_DEAD});
        issue("lh_mis", OP_LOAD, 3'd1, 32'h1003, 32'h0, 5'd4, 1'b1, 32'h1003, 4);
        res_exp.push_back({5'd6, 32'h0000_BEEF});
        issue("lhu_mis", OP_LOAD, 3'd5, 32'h1001, 32'h0, 5'd6, 1'b1, 32'h1001, 4);
        res_exp.push_back({5'd7, 32'h1234_5678});
        issue("l_f3_3", OP_LOAD, 3'd3, 32'h1200, 32'h0, 5'd7, 1'b1, 32'h1200, 6);

        exp_store(32'h1300, 32'h1234_56A5, 1);
        issue("sb", OP_STORE, 3'd0, 32'h1300, 32'h1234_56A5, 5'd9, 1'b1, 32'h1300, 2);
        res_exp.push_back({5'd8, 32'h0000_00A5});
        issue("lbu_sb", OP_LOAD, 3'd4, 32'h1300, 32'h0, 5'd8, 1'b1, 32'h1300, 3);

        exp_store(32'h1500, 32'h0102_0304, 4);
        issue("s_f3_5", OP_STORE, 3'd5, 32'h1500, 32'h0102_0304, 5'd9, 1'b0, 32'h1500, 5);
        res_exp.push_back({5'd10, 32'h0102_0304});
        issue("lw_s5", OP_LOAD, 3'd2, 32'h1500, 32'h0, 5'd10, 1'b1, 32'h1500, 6);

        exp_store(32'h1400, 32'h0000_CAFE, 2);
        fork
            issue("sh_frz", OP_STORE, 3'd1, 32'h1400, 32'h0000_CAFE, 5'd9, 1'b1, 32'h1400, 6);
            begin
                repeat (2) @(posedge clk);
                #1 rdy = 1'b0;
                repeat (3) @(posedge clk);
                #1 rdy = 1'b1;
            end
        join
        res_exp.push_back({5'd11, 32'h0000_CAFE});
        issue("lhu_sh", OP_LOAD, 3'd5, 32'h1400, 32'h0, 5'd11, 1'b1, 32'h1400, 4);

        res_exp.push_back({5'd12, 32'h1234_5678});
        fork
            issue("lw_frz", OP_LOAD, 3'd2, 32'h1200, 32'h0, 5'd12, 1'b1, 32'h1200, 8);
            begin
                repeat (3) @(posedge clk);
                #1 rdy = 1'b0;
                repeat (2) @(posedge clk);
                #1 rdy = 1'b1;
            end
        join

        exp_store(32'h2000, 32'h1122_3344, 2);
        set_in(OP_STORE, 3'd2, 32'h2000, 32'h1122_3344, 5'd9, 1'b1, 32'h2000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        set_in(OP_ADDI, 3'd0, 32'h0, 32'h0, 5'd7, 1'b1, 32'h5555);
        #3;
        check("rstmid_stall", 64'(stall_req_o), 64'd0);
        check("rstmid_wreg", 64'(wreg_o), 64'd0);
        check("rstmid_wd", 64'(wd_o), 64'd0);
        check("rstmid_wdata", 64'(wdata_o), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_in(OP_ADDI, 3'd0, 32'h0, 32'h0, 5'd7, 1'b0, 32'h5555);
        #1;
        check("rstpost_mem_wr", 64'(mem_wr_o), 64'd0);
        check("rstpost_mem_a", 64'(mem_a_o), 64'd0);
        check("rstpost_mem_dout", 64'(mem_dout_o), 64'd0);
        check("rstpost_stall", 64'(stall_req_o), 64'd0);
        @(posedge clk);
        #1;
        res_exp.push_back({5'd13, 32'hFFFF_FF80});
        issue("lb_after_rst", OP_LOAD, 3'd0, 32'h1100, 32'h0, 5'd13, 1'b1, 32'h1100, 3);
        set_in(OP_ADDI, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        check("ram_2002_untouched", 64'(ram.exists(32'h2002)), 64'd0);
        check("wr_left", 64'(wr_exp.size()), 64'd0);
        check("res_left", 64'(res_exp.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
